sequential_divider: RTL
=======================

// Module: sequential_divider
// PURPOSE
//   Unsigned iterative restoring divider; the inverse of sequential_multiplier, same start/ready handshake.
//   Produces one quotient bit per clock. Sits beside the multiplier in the arithmetic datapath.
//   Serves as the decode/inverse path for multiplied values.
// PARAMETERS
//   WORD_LENGTH  8  width of Dividend, Divisor, Quotient and Remainder (>=2)
// PORTS
//   clk           in   1            rising-edge clock
//   reset         in   1            synchronous, active-high reset
//   start         in   1            launch request, acted on at its rising edge only
//   Dividend      in   WORD_LENGTH  numerator, sampled on accept
//   Divisor       in   WORD_LENGTH  denominator, sampled on accept
//   ready         out  1            1 = idle, Quotient/Remainder valid
//   Quotient      out  WORD_LENGTH  floor(Dividend/Divisor)
//   Remainder     out  WORD_LENGTH  Dividend mod Divisor
//   div_by_zero   out  1            present only with SEQ_DIV_ZERO_DETECT_EN
// BEHAVIOUR
//   Clock and reset: single clock clk; reset is synchronous and active-high.
//   Reset: state=IDLE, ready=1, Quotient=0, Remainder=0, div_by_zero=0, start_q=0, count=0.
//   Reset mid-operation: the operation is abandoned, outputs take the reset values, and no result is posted.
//   start_q registers start every cycle. accept = (state==IDLE) & start & ~start_q.
//     Holding start high never retriggers. A rising edge during BUSY is dropped and not queued.
//   FSM (2 states):
//     IDLE --accept--> BUSY: latch working regs q_w=Dividend, d_w=Divisor, r_w=0 (WORD_LENGTH+1 bits); count=0.
//       ready drops to 0 at this edge.
//     BUSY, one restoring step per cycle:
//       t = {r_w[WL-1:0], q_w[WL-1]} - {1'b0,d_w}.
//       If t is non-negative: r_w=t, q_w={q_w[WL-2:0],1}; else r_w=shifted value, q_w={q_w[WL-2:0],0}.
//       count++.
//     On the step where count==WORD_LENGTH-1: Quotient<=final q_w, Remainder<=final r_w[WL-1:0], ready<=1, state->IDLE.
//   Latency: start edge accepted at clock edge k gives ready=1 and valid results after edge k+WORD_LENGTH.
//     ready is low for exactly WORD_LENGTH cycles.
//   Quotient/Remainder hold the previous result throughout BUSY. They change only on completion.
//   Inputs may change freely after the accept edge.
//   A new operation may start the cycle after ready rises, given a fresh rising edge of start.
//   Dividend < Divisor gives Q=0, R=Dividend. Divisor==1 gives Q=Dividend, R=0.
// CONFIGURATION
//   SEQ_DIV_ZERO_DETECT_EN defined:
//     Port div_by_zero exists.
//     Accept with Divisor==0 skips BUSY. On the next edge: Quotient=all ones, Remainder=Dividend, div_by_zero=1, ready=1.
//     ready is low for 1 cycle.
//     div_by_zero clears at the next accept.
//   SEQ_DIV_ZERO_DETECT_EN undefined:
//     No port.
//     Divisor==0 runs the full WORD_LENGTH steps and naturally yields Quotient=all ones, Remainder=Dividend.
// STRUCTURE
//   Shared package/include seq_arith_defs: the state encodings ST_IDLE and ST_BUSY.
//     The multiplier FSM reuses the same encodings.
//   Sub-module div_step (combinational):
//     inputs r_w, q_w msb, d_w; outputs next r_w and quotient bit.
//     Isolates the subtract/restore for unit checking.
//   Counter width: $clog2(WORD_LENGTH).
// TESTING (WORD_LENGTH=8, clk period 4)
//   1 Reset held then released -> ready=1, Quotient=0, Remainder=0.
//   2 Dividend=6, Divisor=3, start pulse -> ready low 8 cycles, then Q=2, R=0.
//   3 251/2 -> Q=125, R=1. 7/9 -> Q=0, R=7. 255/1 -> Q=255, R=0. Results held stable during the next BUSY.
//   4 start held high 4 cycles, then rising again mid-BUSY -> exactly one operation; ready stays 1 afterwards.
//   5 200/0:
//       with macro -> 1-cycle busy, Q=255, R=200, div_by_zero=1; the next 6/3 clears the flag.
//       without macro -> 8 cycles, Q=255, R=200.
//   6 reset asserted 3 cycles into 100/7 -> ready=1, Q=0, R=0, no later result. A fresh 100/7 -> Q=14, R=2.

Source files
------------

// File: rtl/seq_arith_defs_pkg.sv
// seq_arith_defs: definitions shared by the sequential arithmetic blocks
// (sequential_divider and sequential_multiplier).
//
// Contents:
//   seq_state_e        - two-state controller encoding (ST_IDLE / ST_BUSY)
//   SEQ_DEFAULT_WORD   - default operand width used by the arithmetic blocks
//   seq_cnt_width()    - width of a step counter that indexes 0..word-1
package seq_arith_defs;

  // Both the multiplier and the divider controllers use this encoding, so
  // status decode in the surrounding datapath is common to the two blocks.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

  localparam int SEQ_DEFAULT_WORD = 8;

  // Step counter counts 0..word-1; a word length of 2 still needs one bit.
  function automatic int seq_cnt_width(input int word);
    return (word > 2) ? $clog2(word) : 1;
  endfunction

endpackage

// File: rtl/sequential_divider_div_step.sv
// div_step: one combinational restoring-division step.
//
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor, and keeps the difference only when it is non-negative.
//
// Ports:
//   r_w     in   WORD_LENGTH+1  current partial remainder
//   q_msb   in   1              dividend/quotient bit shifted in this step
//   d_w     in   WORD_LENGTH    divisor
//   r_next  out  WORD_LENGTH+1  partial remainder after the step
//   q_bit   out  1              quotient bit produced by the step
module div_step
  import seq_arith_defs::*;
#(
  parameter int WORD_LENGTH = SEQ_DEFAULT_WORD
) (
  input  logic [WORD_LENGTH:0]   r_w,
  input  logic                   q_msb,
  input  logic [WORD_LENGTH-1:0] d_w,
  output logic [WORD_LENGTH:0]   r_next,
  output logic                   q_bit
);

  logic [WORD_LENGTH:0]   shifted;
  logic [WORD_LENGTH+1:0] diff;

  // The partial remainder never exceeds WORD_LENGTH bits, so r_w's top bit
  // is always 0 and {r_w, q_msb} equals the shifted value zero-extended by
  // one bit. That extra bit makes diff's MSB a clean borrow/sign flag.
  always_comb begin
    shifted = {r_w[WORD_LENGTH-1:0], q_msb};
    diff    = {r_w, q_msb} - {2'b00, d_w};
    q_bit   = ~diff[WORD_LENGTH+1];
    r_next  = q_bit ? diff[WORD_LENGTH:0] : shifted;
  end

endmodule

// File: rtl/sequential_divider.sv
// sequential_divider: unsigned iterative restoring divider, one quotient
// bit per clock, start/ready handshake shared with sequential_multiplier.
//
// Ports:
//   clk          in   1            rising-edge clock
//   reset        in   1            synchronous, active-high reset
//   start        in   1            launch request, acted on at its rising edge
//   Dividend     in   WORD_LENGTH  numerator, sampled on accept
//   Divisor      in   WORD_LENGTH  denominator, sampled on accept
//   ready        out  1            1 = idle, Quotient/Remainder valid
//   Quotient     out  WORD_LENGTH  floor(Dividend/Divisor)
//   Remainder    out  WORD_LENGTH  Dividend mod Divisor
//   div_by_zero  out  1            only when SEQ_DIV_ZERO_DETECT_EN is defined
//
// Build option SEQ_DIV_ZERO_DETECT_EN: a zero divisor completes one cycle
// after accept with Quotient=all ones, Remainder=Dividend, div_by_zero=1.
// Without it a zero divisor runs the full sequence, which yields the same
// Quotient/Remainder naturally.
//
// state    | meaning
// ST_IDLE  | waiting for a start rising edge; outputs hold the last result
// ST_BUSY  | one restoring step per cycle until the last bit (or zero-divisor
//          | completion when detection is built in)
module sequential_divider
  import seq_arith_defs::*;
#(
  parameter int WORD_LENGTH = SEQ_DEFAULT_WORD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] Dividend,
  input  logic [WORD_LENGTH-1:0] Divisor,
  output logic                   ready,
  output logic [WORD_LENGTH-1:0] Quotient,
  output logic [WORD_LENGTH-1:0] Remainder
`ifdef SEQ_DIV_ZERO_DETECT_EN
  ,
  output logic                   div_by_zero
`endif
);

  localparam int CNT_W = seq_cnt_width(WORD_LENGTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_LENGTH - 1);

  seq_state_e             state;
  logic                   start_q;
  logic [CNT_W-1:0]       count;
  logic [WORD_LENGTH-1:0] q_w;
  logic [WORD_LENGTH-1:0] d_w;
  logic [WORD_LENGTH:0]   r_w;
  logic [WORD_LENGTH:0]   r_next;
  logic                   q_bit;
  logic                   accept;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic                   zero_pend;
`endif

  // Edge detect: a held start never retriggers, and edges seen while busy
  // are simply lost rather than queued.
  assign accept = (state == ST_IDLE) & start & ~start_q;

  div_step #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_div_step (
    .r_w   (r_w),
    .q_msb (q_w[WORD_LENGTH-1]),
    .d_w   (d_w),
    .r_next(r_next),
    .q_bit (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      Quotient  <= '0;
      Remainder <= '0;
      start_q   <= 1'b0;
      count     <= '0;
      q_w       <= '0;
      d_w       <= '0;
      r_w       <= '0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      zero_pend   <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            q_w   <= Dividend;
            d_w   <= Divisor;
            r_w   <= '0;
            count <= '0;
            ready <= 1'b0;
            state <= ST_BUSY;
`ifdef SEQ_DIV_ZERO_DETECT_EN
            div_by_zero <= 1'b0;
            zero_pend   <= (Divisor == '0);
`endif
          end
        end

        ST_BUSY: begin
`ifdef SEQ_DIV_ZERO_DETECT_EN
          if (zero_pend) begin
            // q_w still holds the untouched dividend here.
            Quotient    <= '1;
            Remainder   <= q_w;
            div_by_zero <= 1'b1;
            zero_pend   <= 1'b0;
            ready       <= 1'b1;
            state       <= ST_IDLE;
          end else
`endif
          begin
            r_w   <= r_next;
            q_w   <= {q_w[WORD_LENGTH-2:0], q_bit};
            count <= count + 1'b1;
            // The last step's results go straight to the outputs so ready
            // rises exactly WORD_LENGTH edges after accept.
            if (count == LAST_STEP) begin
              Quotient  <= {q_w[WORD_LENGTH-2:0], q_bit};
              Remainder <= r_next[WORD_LENGTH-1:0];
              ready     <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
